// File: rtl/bcd_to_bin_if.sv
// Start/done handshake bundle between the digit registers and the BCD-to-binary converter.
// The master drives the request, and the slave (the converter) returns status and result.
interface bcd_to_bin_if #(
   parameter int N_DIGITS = 4,
   parameter int BIN_W    = 14
);
   logic                  start;
   logic [4*N_DIGITS-1:0] bcd_in;
   logic                  ready;
   logic                  done_tick;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;

   modport master (
      output start, bcd_in,
      input  ready, done_tick, bin_out, err
   );

   modport slave (
      input  start, bcd_in,
      output ready, done_tick, bin_out, err
   );
endinterface

// File: rtl/bcd_to_bin.sv
// Iterative BCD-to-binary converter using reverse double-dabble.
// Each OP cycle shifts right once, then subtracts 3 from every digit that is 8 or more.
module bcd_to_bin #(
   parameter int N_DIGITS = 4,
   parameter int BIN_W    = 14
) (
   input  logic          clk,
   input  logic          reset_n,
   bcd_to_bin_if.slave   bus
);

   localparam int BCD_W = 4 * N_DIGITS;
   localparam int CNT_W = (BIN_W > 2) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic [BCD_W-1:0]  bcd_r;
   logic [BCD_W-1:0]  bcd_shifted;
   logic [BCD_W-1:0]  bcd_step;
   logic [BIN_W-1:0]  bin_r;
   logic [CNT_W-1:0]  n_r;
   logic              err_r;
   logic              bad_digit;

   // Any nibble above 9 makes the whole request invalid.
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   always_comb begin
      bcd_shifted = bcd_r >> 1;
      bcd_step    = bcd_shifted;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (bcd_shifted[4*i +: 4] >= 4'd8) bcd_step[4*i +: 4] = bcd_shifted[4*i +: 4] - 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = bad_digit ? DONE : OP;
         OP:      if (n_r == '0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The binary result fills from the top, one bit per cycle, LSB first.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcd_r <= '0;
         bin_r <= '0;
         n_r   <= '0;
         err_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bin_r <= '0;
                  if (bad_digit) begin
                     bcd_r <= '0;
                     err_r <= 1'b1;
                  end else begin
                     bcd_r <= bus.bcd_in;
                     err_r <= 1'b0;
                     n_r   <= CNT_W'(BIN_W - 1);
                  end
               end
            end
            OP: begin
               bin_r <= {bcd_r[0], bin_r[BIN_W-1:1]};
               bcd_r <= bcd_step;
               if (n_r != '0) n_r <= n_r - CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready     = (state == IDLE);
   assign bus.done_tick = (state == DONE);
   assign bus.bin_out   = bin_r;
   assign bus.err       = err_r;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: vector table, random codes against an arithmetic model,
// multi-cycle corner sequences, and an exhaustive 2-digit sweep on a second instance.
module tb_bcd_to_bin;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bcd_to_bin_if #(.N_DIGITS(4), .BIN_W(14)) bus ();
   bcd_to_bin_if #(.N_DIGITS(2), .BIN_W(7))  bus2 ();

   bcd_to_bin #(.N_DIGITS(4), .BIN_W(14)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   bcd_to_bin #(.N_DIGITS(2), .BIN_W(7)) dut2 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bcd;
      int          value;
      logic        bad;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Decimal value straight from the digit weights; invalid codes read as 0.
   function automatic void refModel(input logic [15:0] bcd, input int nd, output int value, output logic bad);
      int weight;
      int d;
      value  = 0;
      bad    = 1'b0;
      weight = 1;
      for (int i = 0; i < nd; i++) begin
         d = int'((bcd >> (4 * i)) & 16'hF);
         if (d > 9) bad = 1'b1;
         value  = value + d * weight;
         weight = weight * 10;
      end
      if (bad) value = 0;
   endfunction

   task automatic applyStimulus(input logic [15:0] bcd);
      bus.start  = 1'b1;
      bus.bcd_in = bcd;
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   task automatic waitDone(input int startCycle, output int cycles);
      cycles = startCycle;
      while (bus.done_tick !== 1'b1 && cycles < 40) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("done_seen", 32'(bus.done_tick), 32'd1);
   endtask

   task automatic runCase(input logic [15:0] bcd, input int expValue, input logic expBad);
      int cycles;
      applyStimulus(bcd);
      waitDone(1, cycles);
      checkOutput("latency", 32'(cycles), expBad ? 32'd1 : 32'd15);
      checkOutput("bin_out", 32'(bus.bin_out), 32'(expValue));
      checkOutput("err", 32'(bus.err), 32'(expBad));
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(bus.done_tick), 32'd0);
      checkOutput("ready_after_done", 32'(bus.ready), 32'd1);
      checkOutput("bin_out_held", 32'(bus.bin_out), 32'(expValue));
   endtask

   initial begin
      int          cycles;
      int          value;
      int          doneCount;
      int          gap;
      logic        bad;
      logic        sawDone;
      logic [15:0] rnd;

      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.bcd_in  = '0;
      bus2.start  = 1'b0;
      bus2.bcd_in = '0;

      vecs.push_back('{16'h0000,    0, 1'b0});
      vecs.push_back('{16'h9999, 9999, 1'b0});
      vecs.push_back('{16'h1234, 1234, 1'b0});
      vecs.push_back('{16'h12A4,    0, 1'b1});
      vecs.push_back('{16'h0042,   42, 1'b0});
      vecs.push_back('{16'h5678, 5678, 1'b0});
      vecs.push_back('{16'h0001,    1, 1'b0});
      vecs.push_back('{16'hF000,    0, 1'b1});
      vecs.push_back('{16'h1000, 1000, 1'b0});
      vecs.push_back('{16'h0909,  909, 1'b0});
      vecs.push_back('{16'h800A,    0, 1'b1});
      vecs.push_back('{16'h0010,   10, 1'b0});

      repeat (3) @(negedge clk);
      checkOutput("reset_ready", 32'(bus.ready), 32'd1);
      checkOutput("reset_done", 32'(bus.done_tick), 32'd0);
      checkOutput("reset_bin", 32'(bus.bin_out), 32'd0);
      checkOutput("reset_err", 32'(bus.err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] vector table");
      foreach (vecs[i]) runCase(vecs[i].bcd, vecs[i].value, vecs[i].bad);

      $display("[TB] random codes");
      for (int n = 0; n < 30; n++) begin
         rnd = 16'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            for (int d = 0; d < 4; d++) rnd[4*d +: 4] = 4'($urandom_range(0, 9));
         end
         refModel(rnd, 4, value, bad);
         runCase(rnd, value, bad);
      end

      $display("[TB] start during OP is ignored");
      applyStimulus(16'h1234);
      repeat (2) @(negedge clk);
      bus.start  = 1'b1;
      bus.bcd_in = 16'h0001;
      @(negedge clk);
      bus.start  = 1'b0;
      waitDone(4, cycles);
      checkOutput("ignore_latency", 32'(cycles), 32'd15);
      checkOutput("ignore_bin", 32'(bus.bin_out), 32'd1234);
      doneCount = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done_tick) doneCount++;
      end
      checkOutput("ignore_extra_done", 32'(doneCount), 32'd0);

      $display("[TB] reset during OP");
      applyStimulus(16'h5678);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_ready", 32'(bus.ready), 32'd1);
      checkOutput("abort_done", 32'(bus.done_tick), 32'd0);
      checkOutput("abort_bin", 32'(bus.bin_out), 32'd0);
      checkOutput("abort_err", 32'(bus.err), 32'd0);
      sawDone = 1'b0;
      repeat (4) begin
         @(negedge clk);
         sawDone = sawDone | bus.done_tick;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         sawDone = sawDone | bus.done_tick;
      end
      checkOutput("abort_no_done", 32'(sawDone), 32'd0);
      runCase(16'h5678, 5678, 1'b0);

      $display("[TB] 2-digit sweep with start held");
      bus2.start  = 1'b1;
      bus2.bcd_in = 8'h00;
      for (int code = 0; code <= 8'h99; code++) begin
         gap = 0;
         do begin
            @(negedge clk);
            gap++;
         end while (bus2.done_tick !== 1'b1 && gap < 30);
         refModel(16'(code), 2, value, bad);
         checkOutput("sweep_done_seen", 32'(bus2.done_tick), 32'd1);
         checkOutput("sweep_bin", 32'(bus2.bin_out), 32'(value));
         checkOutput("sweep_err", 32'(bus2.err), 32'(bad));
         if (code > 0) checkOutput("sweep_spacing", 32'(gap), bad ? 32'd2 : 32'd9);
         if (code < 8'h99) bus2.bcd_in = 8'(code + 1);
      end
      bus2.start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Iterative BCD-to-binary converter. It uses reverse double-dabble: shift right, then subtract 3 from every BCD digit that is ≥ 8. It is the inverse of the binary-to-BCD path built on the add-3 correction cell. It sits between the keypad/display digit registers and the arithmetic datapath, and takes packed BCD digits in over a start/done handshake. One conversion takes BIN_W clock cycles.

## Interface
- N_DIGITS, 4: number of packed BCD digits on bcd_in.
- BIN_W, 14: binary result width; must satisfy 2^BIN_W > 10^N_DIGITS − 1 (14 for 4 digits, 7 for 2 digits).
- clk, input, 1: single clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: conversion request; sampled only in IDLE.
- bcd_in, input, 4*N_DIGITS: packed BCD, digit 0 in bits [3:0]; sampled on the accepting edge only.
- ready, output, 1: high in IDLE (request will be accepted).
- done_tick, output, 1: one-cycle pulse, result/err valid.
- bin_out, output, BIN_W: binary result; held until the next accepted start.
- err, output, 1: last accepted input contained a digit > 9; held until the next accepted start.

## Operation
- States: IDLE, OP, DONE. All outputs are registered or decoded from the state (Moore). There is no combinational path from inputs to outputs.
- Internal registers:
  - bcd_r, 4*N_DIGITS bits.
  - bin_r, BIN_W bits.
  - n_r, a down-counter of ceil(log2(BIN_W)) bits.
- IDLE behaviour:
  - ready = 1.
  - If start = 1 and every digit of bcd_in is ≤ 9: bcd_r ← bcd_in, bin_r ← 0, err ← 0, n_r ← BIN_W−1, next state OP.
  - If start = 1 and any digit is > 9: bcd_r ← 0, bin_r ← 0, err ← 1, next state DONE. No iterations are run.
- OP, each cycle:
  - bin_r ← {bcd_r[0], bin_r[BIN_W−1:1]}.
  - t = bcd_r >> 1.
  - Each 4-bit digit of t is replaced by digit−3 if digit ≥ 8, otherwise kept unchanged.
  - bcd_r ← t.
  - If n_r = 0, next state DONE; otherwise n_r ← n_r−1.
- DONE:
  - done_tick = 1 for exactly this one cycle.
  - Next state IDLE unconditionally.
- bin_out is driven from bin_r and err is a register. Both are stable from the DONE cycle until the next accepted start.
- start while in OP or DONE is ignored. No queuing.
- All arithmetic is unsigned. Digit subtraction never underflows, because it is applied only to digits ≥ 8. For valid input, bcd_r is 0 after the last iteration.

## Timing
- Reset (reset_n low, asynchronous):
  - Registers: state = IDLE, bcd_r = 0, bin_r = 0, n_r = 0, err = 0.
  - Outputs: ready = 1, done_tick = 0, bin_out = 0, err = 0.
- Reset asserted mid-conversion aborts it immediately. No done_tick is issued.
- Valid input, start sampled at edge k:
  - ready drops after edge k.
  - OP occupies cycles k+1 through k+BIN_W.
  - done_tick is high in the cycle after edge k+BIN_W.
  - ready returns after edge k+BIN_W+1.
  - Latency from the start cycle to the done_tick cycle is BIN_W+1 clocks (15 with defaults).
- Invalid input, start at edge k: done_tick with err = 1 in the cycle after edge k, and ready returns one edge later.
- Back-to-back operation: start held high continuously is accepted on the first IDLE cycle after each DONE. Throughput is one conversion per BIN_W+2 cycles.

## Test plan
- Reset, then start with bcd_in = 16'h0000. Required: done_tick exactly 15 cycles after the start cycle, bin_out = 0, err = 0, ready = 1 on the following cycle.
- bcd_in = 16'h9999. Required: bin_out = 14'd9999 (0x270F), err = 0.
- Start with bcd_in = 16'h1234, then pulse start again during OP with bcd_in = 16'h0001. Required: the second pulse is ignored, result 1234, exactly one done_tick.
- bcd_in = 16'h12A4. Required: done_tick in the next cycle, err = 1, bin_out = 0. A following start with 16'h0042 gives bin_out = 42 and err = 0.
- Assert reset_n low at the 7th OP cycle of a 16'h5678 conversion. Required: done_tick is never asserted, outputs are 0 and ready = 1 while in reset. After release, 16'h5678 converts to 5678.
- With N_DIGITS = 2, BIN_W = 7, sweep all inputs 0x00–0x99 with start held high. Required: bin_out equals the decimal value for every valid code, err = 1 for codes with a nibble > 9, and conversions are spaced 9 cycles apart.
